// File: rtl/pc_fetch_ctrl.sv
// Program-counter and fetch sequencer for the single-cycle core, driving the branch-target LUT.
// Optional taken-branch counter is built only when PC_BRANCH_CNT_EN is defined.
//
// state  | meaning
// IDLE   | after reset, PC parked at 0, waiting for Start
// RUN    | fetching; PC advances sequentially or by branch unless stalled
// HALTED | halt retired; PC and counters frozen until the next Start
module pc_fetch_ctrl #(
  parameter int PC_W       = 10,
  parameter int IDX_W      = 5,
  parameter int LUT_W      = 8,
  parameter int START_ADDR = 0
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic             Stall,
  input  logic             Halt,
  input  logic             BranchAbs,
  input  logic             BranchRel,
  input  logic [IDX_W-1:0] TargetIdx,
  output logic [IDX_W-1:0] LutIndex,
  input  logic [LUT_W-1:0] LutValue,
  output logic [PC_W-1:0]  PC,
  output logic             Running,
  output logic             Done,
  output logic [15:0]      InstrCount,
  output logic [7:0]       BranchCnt
);

  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

  state_t          state, state_nxt;
  logic [PC_W-1:0] pc_q, pc_nxt;
  logic [15:0]     icnt_q, icnt_nxt;
  logic            done_q, done_nxt;
  logic            start_load;
  logic            taken;

  // LUT values are narrower than the PC; extend to PC width before use.
  logic [PC_W-1:0] abs_target;
  logic [PC_W-1:0] rel_offset;
  assign abs_target = {{(PC_W-LUT_W){1'b0}}, LutValue};
  assign rel_offset = {{(PC_W-LUT_W){LutValue[LUT_W-1]}}, LutValue};

  assign LutIndex   = TargetIdx;
  assign PC         = pc_q;
  assign Running    = (state == RUN);
  assign Done       = done_q;
  assign InstrCount = icnt_q;

  assign start_load = (state != RUN) && Start;
  assign taken      = (state == RUN) && !Stall && !Halt && (BranchAbs || BranchRel);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state  <= IDLE;
      pc_q   <= '0;
      icnt_q <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      pc_q   <= pc_nxt;
      icnt_q <= icnt_nxt;
      done_q <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_q;
    icnt_nxt  = icnt_q;
    done_nxt  = 1'b0;
    case (state)
      IDLE, HALTED: begin
        if (Start) begin
          state_nxt = RUN;
          pc_nxt    = PC_W'(START_ADDR);
          icnt_nxt  = '0;
        end
      end
      RUN: begin
        if (!Stall) begin
          if (icnt_q != 16'hFFFF) icnt_nxt = icnt_q + 16'd1;
          if (Halt) begin
            state_nxt = HALTED;
            done_nxt  = 1'b1;
          end else if (BranchAbs) begin
            pc_nxt = abs_target;
          end else if (BranchRel) begin
            pc_nxt = pc_q + rel_offset;
          end else begin
            pc_nxt = pc_q + PC_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef PC_BRANCH_CNT_EN
  logic [7:0] bcnt_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      bcnt_q <= '0;
    end else if (start_load) begin
      bcnt_q <= '0;
    end else if (taken && (bcnt_q != 8'hFF)) begin
      bcnt_q <= bcnt_q + 8'd1;
    end
  end

  assign BranchCnt = bcnt_q;
`else
  assign BranchCnt = 8'h00;
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Scoreboard bench for pc_fetch_ctrl: a cycle-level reference model queues expected outputs,
// and a negedge monitor compares them against the DUT. Honours PC_BRANCH_CNT_EN.
module tb_pc_fetch_ctrl;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       Start = 1'b0, Stall = 1'b0, Halt = 1'b0, BranchAbs = 1'b0, BranchRel = 1'b0;
  logic [4:0] TargetIdx = '0;
  logic [4:0] LutIndex;
  logic [7:0] LutValue = '0;
  logic [9:0] PC;
  logic       Running, Done;
  logic [15:0] InstrCount;
  logic [7:0]  BranchCnt;

  pc_fetch_ctrl dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Stall(Stall), .Halt(Halt),
    .BranchAbs(BranchAbs), .BranchRel(BranchRel), .TargetIdx(TargetIdx),
    .LutIndex(LutIndex), .LutValue(LutValue), .PC(PC), .Running(Running),
    .Done(Done), .InstrCount(InstrCount), .BranchCnt(BranchCnt)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int pc;
    int running;
    int done;
    int icnt;
    int bcnt;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;

  // Reference model: the program is either running or not; nothing else is remembered.
  int m_pc = 0, m_icnt = 0, m_bcnt = 0;
  bit m_run = 0;

  task automatic chk(string name, int act, int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge Clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("pc", int'(PC), e.pc);
      chk("running", int'(Running), e.running);
      chk("done", int'(Done), e.done);
      chk("instr_count", int'(InstrCount), e.icnt);
      chk("branch_cnt", int'(BranchCnt), e.bcnt);
    end
  end

  task automatic model_reset();
    m_pc = 0; m_icnt = 0; m_bcnt = 0; m_run = 0;
  endtask

  function automatic int model_cycle(bit st, bit sl, bit h, bit ba, bit br, int lv);
    int done = 0;
    int off;
    bit counted = 0;
    if (!m_run) begin
      if (st) begin
        m_run = 1; m_pc = 0; m_icnt = 0; m_bcnt = 0;
      end
    end else if (!sl) begin
      if (m_icnt < 65535) m_icnt++;
      if (h) begin
        m_run = 0;
        done = 1;
      end else if (ba) begin
        m_pc = lv;
        counted = 1;
      end else if (br) begin
        off = (lv >= 128) ? lv - 256 : lv;
        m_pc = ((m_pc + off) % 1024 + 1024) % 1024;
        counted = 1;
      end else begin
        m_pc = (m_pc + 1) % 1024;
      end
    end
`ifdef PC_BRANCH_CNT_EN
    if (counted && m_bcnt < 255) m_bcnt++;
`else
    if (counted) m_bcnt = 0;
`endif
    return done;
  endfunction

  // Called at negedge+1; drives one cycle of inputs and queues the post-edge expectation.
  task automatic step(bit st, bit sl, bit h, bit ba, bit br, int idx, int lv);
    exp_t e;
    int d;
    Start = st; Stall = sl; Halt = h; BranchAbs = ba; BranchRel = br;
    TargetIdx = 5'(idx); LutValue = 8'(lv);
    #1;
    chk("lut_index", int'(LutIndex), idx);
    d = model_cycle(st, sl, h, ba, br, lv);
    e.pc = m_pc; e.running = m_run; e.done = d; e.icnt = m_icnt; e.bcnt = m_bcnt;
    q.push_back(e);
    @(posedge Clk);
    @(negedge Clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) @(negedge Clk);
    chk("rst_pc", int'(PC), 0);
    chk("rst_running", int'(Running), 0);
    chk("rst_done", int'(Done), 0);
    chk("rst_icnt", int'(InstrCount), 0);
    chk("rst_bcnt", int'(BranchCnt), 0);
    #1 Reset_n = 1'b1;
    @(negedge Clk); #1;

    // idle ignores everything but Start
    step(0, 0, 0, 1, 0, 3, 99);
    step(1, 0, 0, 0, 0, 0, 0);
    repeat (5) step(0, 0, 0, 0, 0, 0, 0);
    // reach PC 3 then absolute branch to 17
    step(0, 0, 0, 1, 0, 3, 3);
    step(0, 0, 0, 1, 0, 17, 17);
    // relative branches with wrap
    step(0, 0, 0, 1, 0, 2, 2);
    step(0, 0, 0, 0, 1, 4, 8'hFE);
    step(0, 0, 0, 0, 1, 4, 8'hFF);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 1023 % 256);
    step(0, 0, 0, 1, 1, 9, 200);
    step(0, 0, 0, 0, 1, 9, 8'h80);
    step(1, 0, 0, 0, 0, 0, 0);
    // stall masks halt and branch, then halt
    repeat (3) step(0, 1, 1, 1, 0, 5, 77);
    step(0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 1, 1, 6, 66);
    step(0, 0, 0, 1, 0, 6, 66);
    // restart from HALTED, reach PC 40, then async reset between edges
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 8, 39);
    step(0, 0, 0, 0, 0, 0, 0);
    #2 Reset_n = 1'b0;
    #1;
    chk("async_rst_pc", int'(PC), 0);
    chk("async_rst_running", int'(Running), 0);
    chk("async_rst_icnt", int'(InstrCount), 0);
    chk("async_rst_bcnt", int'(BranchCnt), 0);
    model_reset();
    @(negedge Clk); #1 Reset_n = 1'b1;
    step(1, 0, 0, 0, 0, 0, 0);
    repeat (2) step(0, 0, 0, 0, 0, 0, 0);

`ifdef PC_BRANCH_CNT_EN
    step(0, 0, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 300; i++) step(0, 0, 0, i[0], ~i[0], 1, 5);
    step(0, 0, 1, 1, 0, 2, 9);
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0, 2, 9);
`endif

    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           int'($urandom_range(0, 31)), int'($urandom_range(0, 255)));
    end

    @(negedge Clk); #1;
    chk("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Program-counter and fetch sequencer for the single-cycle core; the initiator side of the branch-target lookup.
- Drives a 5-bit target index to the combinational PC LUT and consumes its 8-bit target value on taken branches.
- Sequences the program between Start and Halt, and reports completion to the test harness with a Done pulse.

Parameters:
- PC_W, 10, program counter width in bits (instruction-memory address).
- IDX_W, 5, branch-target LUT index width.
- LUT_W, 8, branch-target LUT value width.
- START_ADDR, 0, PC loaded on every Start.

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- Start  input  1  one-cycle request to begin execution at START_ADDR.
- Stall  input  1  freezes the PC and counters for the cycle while running.
- Halt  input  1  decoded halt instruction at the current PC.
- BranchAbs  input  1  taken absolute branch: PC <= LUT value.
- BranchRel  input  1  taken relative branch: PC <= PC + signed LUT value.
- TargetIdx  input  IDX_W  LUT index field from the current instruction.
- LutIndex  output  IDX_W  index to the PC LUT; combinational copy of TargetIdx.
- LutValue  input  LUT_W  target value returned by the PC LUT.
- PC  output  PC_W  current instruction address.
- Running  output  1  high in the RUN state.
- Done  output  1  one-cycle pulse on entry to HALTED.
- InstrCount  output  16  count of instructions retired since the last Start.
- BranchCnt  output  8  taken-branch count (see Optional Feature).

Behaviour:
- Reset (Reset_n low, any time, including mid-run):
  - State goes to IDLE immediately.
  - PC, InstrCount and BranchCnt go to 0; Running and Done go to 0.
- States:
  - IDLE: PC holds at 0. Start -> RUN, PC <= START_ADDR, InstrCount <= 0, BranchCnt <= 0.
  - RUN: described below.
  - HALTED: PC and counters hold. Start -> RUN with the same loads as from IDLE. No other input has effect.
- RUN, Stall high:
  - No state, PC or counter change.
  - Halt and both branch inputs are ignored for that cycle.
- RUN, Stall low, priority order Halt > BranchAbs > BranchRel > sequential:
  - Halt: PC holds, state -> HALTED, Done = 1 for exactly the next cycle.
  - BranchAbs: PC <= zero-extended LutValue.
  - BranchRel: PC <= PC + sign-extended LutValue (LUT_W two's complement), mod 2^PC_W. Wrap-around is silent: PC 0 + (-1) gives 2^PC_W - 1.
  - Otherwise: PC <= PC + 1, mod 2^PC_W. PC 1023 wraps to 0.
  - If BranchAbs and BranchRel are both high, BranchAbs wins.
- Start while in RUN is ignored.
- Latency:
  - New PC is visible one cycle after the deciding edge.
  - LutIndex tracks TargetIdx with zero latency; LutValue is sampled on the same edge as the branch decision.
- InstrCount:
  - Increments on every non-stalled RUN cycle, the Halt cycle included.
  - Saturates at 0xFFFF.
- Running = 1 exactly while state is RUN.

Optional Feature:
- Macro: PC_BRANCH_CNT_EN.
- Defined: BranchCnt increments on each non-stalled RUN cycle where BranchAbs or BranchRel is taken and Halt is low. It saturates at 0xFF and clears on Start and on reset.
- Undefined: BranchCnt is tied to 0 and no counter flop is built.

Test Plan:
- Reset then Start, no branches, 5 cycles -> PC sequence 0,1,2,3,4,5; InstrCount = 5; Running = 1.
- At PC = 3, BranchAbs with TargetIdx = 17 and LUT returning 17 -> LutIndex = 17 same cycle; PC = 17 next cycle.
- At PC = 2, BranchRel with LutValue = 0xFE -> PC = 0. At PC = 0, BranchRel with 0xFF -> PC = 1023.
- Stall held for 3 cycles with Halt and BranchAbs high -> PC and InstrCount unchanged. Stall released with Halt high -> HALTED, Done pulses exactly 1 cycle, PC holds.
- Reset_n asserted low mid-RUN at PC = 40, asynchronously between edges -> PC = 0, Running = 0 immediately. Start afterwards -> restarts at START_ADDR with counters cleared.
- With PC_BRANCH_CNT_EN defined: 300 taken branches -> BranchCnt = 255. BranchAbs coinciding with Halt -> not counted, HALTED entered.
